// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with synchronous parallel load, terminal carry/borrow and bad-load flag.
// Build option: define BCD_SATURATE_EN to hold at all 9s / all 0s instead of wrapping.
module bcd_updown_counter #(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic                  borrow,
    output logic                  bad_load
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0]      count_q, count_d;
    logic              bad_load_q, bad_load_d;
    logic [DIGITS-1:0] step;
    logic              term;
    logic              run;
    logic [3:0]        dig;

    // step[i]: every lower digit sits at its terminal value (9 up, 0 down); term covers all digits
    always_comb begin
        step = '0;
        run  = 1'b1;
        dig  = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            step[i] = run;
            dig     = count_q[4*i +: 4];
            run     = run & (up ? (dig == 4'd9) : (dig == 4'd0));
        end
        term = run;
    end

    always_comb begin
        count_d    = count_q;
        bad_load_d = 1'b0;
        if (load) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (load_val[4*i +: 4] > 4'd9) begin
                    count_d[4*i +: 4] = 4'd0;
                    bad_load_d        = 1'b1;
                end else begin
                    count_d[4*i +: 4] = load_val[4*i +: 4];
                end
            end
`ifdef BCD_SATURATE_EN
        end else if (en && !term) begin
`else
        end else if (en) begin
`endif
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (step[i]) begin
                    if (up) begin
                        count_d[4*i +: 4] = (count_q[4*i +: 4] == 4'd9) ? 4'd0 : count_q[4*i +: 4] + 4'd1;
                    end else begin
                        count_d[4*i +: 4] = (count_q[4*i +: 4] == 4'd0) ? 4'd9 : count_q[4*i +: 4] - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            bad_load_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            bad_load_q <= bad_load_d;
        end
    end

    assign count    = count_q;
    assign bad_load = bad_load_q;
    assign carry    = en & up & ~load & term;
    assign borrow   = en & ~up & ~load & term;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench for bcd_updown_counter: integer-valued reference model plus directed literal pins.
// Honours BCD_SATURATE_EN when defined for the build.
module tb_bcd_updown_counter;

    logic        clk = 1'b0;
    logic        rst, en, up, load;
    logic [7:0]  lv2;
    logic [15:0] lv4;
    logic [7:0]  count2;
    logic [15:0] count4;
    logic        carry2, borrow2, bad2;
    logic        carry4, borrow4, bad4;

    int n_tests = 0;
    int n_fail  = 0;

    int m2, m4;
    bit mb2, mb4;

    // literal pins requested by the stimulus, checked by the compare process
    bit          pin_v = 1'b0;
    string       pin_name;
    logic [7:0]  pin_cnt;
    int          pin_fsel;
    bit          pin_fexp;
    bit          pin4_v = 1'b0;
    logic [15:0] pin4_cnt;
    bit          pin4_carry;

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv2),
        .count(count2), .carry(carry2), .borrow(borrow2), .bad_load(bad2)
    );

    bcd_updown_counter #(.DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv4),
        .count(count4), .carry(carry4), .borrow(borrow4), .bad_load(bad4)
    );

    function automatic int pow10(int d);
        int r = 1;
        for (int i = 0; i < d; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(int v, int d);
        logic [15:0] r = '0;
        int x = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int model_next(int val, int d, logic [15:0] lv, bit ld, bit e, bit u, output bit bad);
        int lim = pow10(d);
        int r = 0;
        bad = 1'b0;
        if (ld) begin
            for (int i = d - 1; i >= 0; i--) begin
                int dg = int'(lv[4*i +: 4]);
                if (dg > 9) begin
                    bad = 1'b1;
                    dg = 0;
                end
                r = r * 10 + dg;
            end
            return r;
        end
        if (!e) return val;
`ifdef BCD_SATURATE_EN
        if (u) return (val == lim - 1) ? val : val + 1;
        return (val == 0) ? val : val - 1;
`else
        if (u) return (val + 1) % lim;
        return (val + lim - 1) % lim;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m2 <= 0; mb2 <= 1'b0;
            m4 <= 0; mb4 <= 1'b0;
        end else begin
            bit b2, b4;
            int n2, n4;
            n2 = model_next(m2, 2, {8'h00, lv2}, load, en, up, b2);
            n4 = model_next(m4, 4, lv4, load, en, up, b4);
            m2 <= n2; mb2 <= b2;
            m4 <= n4; mb4 <= b4;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [15:0] e2, e4;
        e2 = to_bcd(m2, 2);
        e4 = to_bcd(m4, 4);
        chk("count2",  32'(count2),  32'(e2[7:0]));
        chk("carry2",  32'(carry2),  32'(en & up & ~load & (m2 == 99)));
        chk("borrow2", 32'(borrow2), 32'(en & ~up & ~load & (m2 == 0)));
        chk("bad2",    32'(bad2),    32'(mb2));
        chk("count4",  32'(count4),  32'(e4));
        chk("carry4",  32'(carry4),  32'(en & up & ~load & (m4 == 9999)));
        chk("borrow4", 32'(borrow4), 32'(en & ~up & ~load & (m4 == 0)));
        chk("bad4",    32'(bad4),    32'(mb4));
        if (pin_v) begin
            chk({"pin_cnt_", pin_name}, 32'(count2), 32'(pin_cnt));
            case (pin_fsel)
                1: chk({"pin_carry_", pin_name},  32'(carry2),  32'(pin_fexp));
                2: chk({"pin_borrow_", pin_name}, 32'(borrow2), 32'(pin_fexp));
                3: chk({"pin_bad_", pin_name},    32'(bad2),    32'(pin_fexp));
                default: ;
            endcase
        end
        if (pin4_v) begin
            chk({"pin4_cnt_", pin_name},   32'(count4), 32'(pin4_cnt));
            chk({"pin4_carry_", pin_name}, 32'(carry4), 32'(pin4_carry));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pin2(input string name, input logic [7:0] c, input int fsel, input bit fexp);
        pin_name = name; pin_cnt = c; pin_fsel = fsel; pin_fexp = fexp; pin_v = 1'b1;
        @(negedge clk);
        #1 pin_v = 1'b0;
    endtask

    task automatic pin4(input string name, input logic [15:0] c, input bit cy);
        pin_name = name; pin4_cnt = c; pin4_carry = cy; pin4_v = 1'b1;
        @(negedge clk);
        #1 pin4_v = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; lv2 = '0; lv4 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        pin2("reset", 8'h00, 3, 1'b0);

        // count up through the full range
        en = 1'b1; up = 1'b1;
        repeat (99) tick();
        pin2("up99", 8'h99, 1, 1'b1);
        tick();
`ifdef BCD_SATURATE_EN
        pin2("up_sat", 8'h99, 1, 1'b1);
`else
        pin2("up_wrap", 8'h00, 1, 1'b0);
`endif

        // load 42 then count down through zero
        en = 1'b0; load = 1'b1; lv2 = 8'h42;
        tick();
        load = 1'b0;
        pin2("load42", 8'h42, 3, 1'b0);
        en = 1'b1; up = 1'b0;
        repeat (42) tick();
        pin2("dn00", 8'h00, 2, 1'b1);
        tick();
`ifdef BCD_SATURATE_EN
        pin2("dn_sat", 8'h00, 2, 1'b1);
`else
        pin2("dn_wrap", 8'h99, 2, 1'b0);
`endif

        // invalid digit load with en high: load wins, bad digit stored as 0
        load = 1'b1; lv2 = 8'h5A; en = 1'b1; up = 1'b1;
        tick();
        load = 1'b0; en = 1'b0;
        pin2("bad5A", 8'h50, 3, 1'b1);
        tick();
        pin2("bad_clear", 8'h50, 3, 1'b0);

        // direction toggling every clock
        load = 1'b1; lv2 = 8'h37;
        tick();
        load = 1'b0; en = 1'b1;
        up = 1'b1; tick(); pin2("tog38a", 8'h38, 0, 1'b0);
        up = 1'b0; tick(); pin2("tog37a", 8'h37, 0, 1'b0);
        up = 1'b1; tick(); pin2("tog38b", 8'h38, 0, 1'b0);
        up = 1'b0; tick(); pin2("tog37b", 8'h37, 0, 1'b0);
        en = 1'b0; tick(); pin2("hold37", 8'h37, 0, 1'b0);

        // async reset between edges
        load = 1'b1; lv2 = 8'h73; en = 1'b1; up = 1'b1;
        tick();
        load = 1'b0; en = 1'b0;
        pin2("load73", 8'h73, 0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        pin2("async_rst", 8'h00, 0, 1'b0);
        rst = 1'b0;
        en = 1'b1; up = 1'b1;
        tick();
        pin2("resume01", 8'h01, 0, 1'b0);

        // four-digit wrap with carry
        en = 1'b0; load = 1'b1; lv4 = 16'h9999; lv2 = 8'h99;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        pin4("w9999", 16'h9999, 1'b1);
        tick();
`ifdef BCD_SATURATE_EN
        pin4("w4_sat", 16'h9999, 1'b1);
`else
        pin4("w4_wrap", 16'h0000, 1'b0);
`endif
        en = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
